// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter that applies one requester's toggle mask at a time to a shared T-bit bank.
// Each grant goes through IDLE -> APPLY -> COOL, so grants are at least three cycles apart.
module tff_toggle_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_mask,
    input  logic                    clear,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic                    busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [PTR_W-1:0]   win, win_n;
    logic [WIDTH-1:0]   mask_cap, mask_n;
    logic [WIDTH-1:0]   q_n;
    logic [NREQ-1:0]    gnt_n;

    logic               found;
    logic [PTR_W-1:0]   sel;
    logic [WIDTH-1:0]   sel_mask;

    // First set request at or after ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
        sel_mask = req_mask[32'(sel)*WIDTH +: WIDTH];
    end

    // Next-state and registered-output logic; clear overrides any toggle.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        mask_n  = mask_cap;
        q_n     = q;
        gnt_n   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    win_n   = sel;
                    mask_n  = sel_mask;
                    state_n = APPLY;
                end
            end
            APPLY: begin
                q_n     = q ^ mask_cap;
                gnt_n   = NREQ'(1) << win;
                ptr_n   = (32'(win) == NREQ - 1) ? '0 : win + PTR_W'(1);
                state_n = COOL;
            end
            COOL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (clear) begin
            q_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            mask_cap <= '0;
            q        <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            win      <= win_n;
            mask_cap <= mask_n;
            q        <= q_n;
            gnt      <= gnt_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed bench for tff_toggle_arbiter: reset, single grant, round robin, wrap, clear collision, mask capture.
module tb_tff_toggle_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_mask;
    logic                  clear;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    int vectors = 0;
    int errors  = 0;

    tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_mask (req_mask),
        .clear    (clear),
        .gnt      (gnt),
        .q        (q),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input int unsigned i, input logic [WIDTH-1:0] m);
        req_mask[i*WIDTH +: WIDTH] = m;
    endtask

    // Acceptance edge: FSM leaves IDLE, no grant yet.
    task automatic accept(input string tag);
        step();
        chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
        chk({tag, "_acc_gnt"},  32'(gnt),  32'd0);
    endtask

    // Apply edge: grant pulse and bank update.
    task automatic apply(input string tag, input logic [NREQ-1:0] eg, input logic [WIDTH-1:0] eq);
        step();
        chk({tag, "_gnt"},  32'(gnt),  32'(eg));
        chk({tag, "_q"},    32'(q),    32'(eq));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Cool edge: grant drops, back to IDLE.
    task automatic cool(input string tag);
        step();
        chk({tag, "_cool_gnt"},  32'(gnt),  32'd0);
        chk({tag, "_cool_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic grant_cycle(input string tag, input logic [NREQ-1:0] eg, input logic [WIDTH-1:0] eq);
        accept(tag);
        apply(tag, eg, eq);
        cool(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_mask = '0;
        clear    = 1'b0;
        step();
        step();
        chk("rst_q",    32'(q),    32'd0);
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Single requester, same mask twice; ptr ends at 1.
        set_mask(0, 8'hA5);
        req = 4'b0001;
        grant_cycle("single1", 4'b0001, 8'hA5);
        grant_cycle("single2", 4'b0001, 8'h00);
        // Requester 1 from ptr=1: q=C3, ptr=2.
        set_mask(1, 8'hC3);
        req = 4'b0010;
        grant_cycle("req1", 4'b0010, 8'hC3);

        // Asynchronous reset in APPLY: winner would have been 2 (ptr=2).
        set_mask(2, 8'h3C);
        req = 4'b0101;
        accept("prerst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q",    32'(q),    32'd0);
        chk("arst_gnt",  32'(gnt),  32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        // ptr=0 after reset, so requester 0 wins first.
        grant_cycle("postrst0", 4'b0001, 8'hA5);
        req = 4'b0100;
        grant_cycle("postrst2", 4'b0100, 8'h99);
        req = 4'b0000;

        // Clear in IDLE.
        clear = 1'b1;
        step();
        chk("clr_idle_q",    32'(q),    32'd0);
        chk("clr_idle_busy", 32'(busy), 32'd0);
        clear = 1'b0;

        // Pointer wrap: ptr=3, req=1001 -> 3 then 0.
        set_mask(0, 8'h01);
        set_mask(1, 8'h02);
        set_mask(2, 8'h04);
        set_mask(3, 8'h08);
        req = 4'b1001;
        grant_cycle("wrap3", 4'b1000, 8'h08);
        req = 4'b0001;
        grant_cycle("wrap0", 4'b0001, 8'h09);
        // ptr=1: grant 3 to move ptr back to 0.
        req = 4'b1000;
        grant_cycle("align3", 4'b1000, 8'h01);
        req = 4'b0000;
        clear = 1'b1;
        step();
        chk("clr2_q", 32'(q), 32'd0);
        clear = 1'b0;

        // Fairness with all requests held.
        req = 4'b1111;
        grant_cycle("rr0", 4'b0001, 8'h01);
        grant_cycle("rr1", 4'b0010, 8'h03);
        grant_cycle("rr2", 4'b0100, 8'h07);
        grant_cycle("rr3", 4'b1000, 8'h0F);
        grant_cycle("rr4", 4'b0001, 8'h0E);
        req = 4'b0000;

        // ptr=1: build q=FF, then clear collides with the 0F toggle.
        set_mask(1, 8'hF1);
        req = 4'b0010;
        grant_cycle("mkff", 4'b0010, 8'hFF);
        set_mask(2, 8'h0F);
        req = 4'b0100;
        accept("clrcol");
        clear = 1'b1;
        apply("clrcol", 4'b0100, 8'h00);
        clear = 1'b0;
        cool("clrcol");
        // ptr must be 3 now: req=0101 picks 0, not 2.
        req = 4'b0101;
        grant_cycle("ptradv", 4'b0001, 8'h01);
        req = 4'b0000;

        // Zero mask: grant still pulses, q unchanged (ptr 1 -> 2).
        set_mask(1, 8'h00);
        req = 4'b0010;
        grant_cycle("zmask", 4'b0010, 8'h01);
        // Mask changed after acceptance: captured 11 is applied.
        set_mask(2, 8'h11);
        req = 4'b0100;
        accept("mchg");
        set_mask(2, 8'h22);
        apply("mchg", 4'b0100, 8'h10);
        req = 4'b0000;
        cool("mchg");

        step();
        step();
        chk("end_gnt",  32'(gnt),  32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_q",    32'(q),    32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
